// File: rtl/ssp_rx_port.sv
// SSP receive engine: synchronizes SSPCLKIN/SSPFSSIN/SSPRXD onto PCLK, deserializes frames MSB first
// into a small FIFO popped over PSEL/PWRITE. Optional sticky overrun flag SSPRXOR under SSP_RX_OVERRUN_EN.
module ssp_rx_port #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  PCLK,
  input  logic                  CLEAR,
  input  logic                  PSEL,
  input  logic                  PWRITE,
  input  logic                  SSPCLKIN,
  input  logic                  SSPFSSIN,
  input  logic                  SSPRXD,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  SSPRXINTR,
  output logic                  SSPRXEMPTY
`ifdef SSP_RX_OVERRUN_EN
  ,
  output logic                  SSPRXOR
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] clk_sync, fss_sync, rxd_sync;
  logic                   clk_prev_p1, fe_p1, fss_p1, rxd_p1;
  state_t                 state, state_n;
  logic [BIT_W-1:0]       bitcnt, bitcnt_n;
  logic [DATA_WIDTH-1:0]  shreg, shreg_n;
  logic                   push_n, push_p2;

  logic [DATA_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wptr, rptr, wptr_n, rptr_n;
  logic [CNT_W-1:0]       count, count_n;
  logic [DATA_WIDTH-1:0]  head_n;
  logic                   full, pop, do_push, drop;

  // Stage p0: synchronizer chains
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      clk_sync <= '0;
      fss_sync <= '0;
      rxd_sync <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], SSPCLKIN};
      fss_sync <= {fss_sync[SYNC_STAGES-2:0], SSPFSSIN};
      rxd_sync <= {rxd_sync[SYNC_STAGES-2:0], SSPRXD};
    end
  end

  // Stage p1: falling-edge strobe with frame sync and data aligned to it
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      clk_prev_p1 <= 1'b0;
      fe_p1       <= 1'b0;
      fss_p1      <= 1'b0;
      rxd_p1      <= 1'b0;
    end else begin
      clk_prev_p1 <= clk_sync[SYNC_STAGES-1];
      fe_p1       <= clk_prev_p1 & ~clk_sync[SYNC_STAGES-1];
      fss_p1      <= fss_sync[SYNC_STAGES-1];
      rxd_p1      <= rxd_sync[SYNC_STAGES-1];
    end
  end

  // Stage p2: frame FSM and shift register; push request is registered
  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      state   <= IDLE;
      bitcnt  <= '0;
      shreg   <= '0;
      push_p2 <= 1'b0;
    end else begin
      state   <= state_n;
      bitcnt  <= bitcnt_n;
      shreg   <= shreg_n;
      push_p2 <= push_n;
    end
  end

  always_comb begin
    state_n  = state;
    bitcnt_n = bitcnt;
    shreg_n  = shreg;
    push_n   = 1'b0;
    case (state)
      IDLE: begin
        if (fe_p1 && fss_p1) begin
          state_n  = SHIFT;
          bitcnt_n = '0;
        end
      end
      SHIFT: begin
        if (fe_p1) begin
          if (bitcnt == LAST_BIT) begin
            // FSS on the LSB edge starts the next frame immediately
            shreg_n  = {shreg[DATA_WIDTH-2:0], rxd_p1};
            push_n   = 1'b1;
            bitcnt_n = '0;
            state_n  = fss_p1 ? SHIFT : IDLE;
          end else if (fss_p1) begin
            shreg_n  = '0;
            bitcnt_n = '0;
          end else begin
            shreg_n  = {shreg[DATA_WIDTH-2:0], rxd_p1};
            bitcnt_n = bitcnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign full       = (count == FULL_CNT);
  assign pop        = PSEL & ~PWRITE & (count != '0);
  assign do_push    = push_p2 & (~full | pop);
  assign drop       = push_p2 & full & ~pop;
  assign SSPRXEMPTY = (count == '0);
  assign SSPRXINTR  = full;

  always_comb begin
    wptr_n  = do_push ? wptr + 1'b1 : wptr;
    rptr_n  = pop ? rptr + 1'b1 : rptr;
    count_n = count;
    if (do_push && !pop)
      count_n = count + 1'b1;
    else if (!do_push && pop)
      count_n = count - 1'b1;
    // The slot being written is the new head only when it is the sole occupant after this cycle
    if (count_n == '0)
      head_n = '0;
    else if (do_push && (wptr == rptr_n))
      head_n = shreg;
    else
      head_n = mem[rptr_n];
  end

  // Stage p3: FIFO storage and registered head word
  always_ff @(posedge PCLK) begin
    if (do_push)
      mem[wptr] <= shreg;
  end

  always_ff @(posedge PCLK) begin
    if (CLEAR) begin
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      PRDATA <= '0;
    end else begin
      wptr   <= wptr_n;
      rptr   <= rptr_n;
      count  <= count_n;
      PRDATA <= head_n;
    end
  end

`ifdef SSP_RX_OVERRUN_EN
  always_ff @(posedge PCLK) begin
    if (CLEAR)
      SSPRXOR <= 1'b0;
    else if (drop)
      SSPRXOR <= 1'b1;
    else if (pop)
      SSPRXOR <= 1'b0;
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule
